// File: rtl/tetris_input_sched_if.sv
// tetris_input_sched_if: valid/ready command port from the input scheduler to the game engine.
interface tetris_input_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/tetris_input_sched.sv
// tetris_input_sched: edge detect, DAS/ARR auto-repeat and fixed-priority arbitration
// of five button levels onto one valid/ready command stream.
module tetris_input_sched #(
    parameter int DAS_TICKS = 16,
    parameter int ARR_TICKS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_tick,
    input  logic                        i_enable,
    input  logic [4:0]                  i_btn_lvl,
    tetris_input_sched_if.master        cmd
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_st_t;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_TICKS - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_TICKS - 1);

    logic [4:0]       r_prev;
    logic [4:0]       r_req;
    logic             r_valid;
    logic [2:0]       r_code;
    rep_st_t          r_st [3];
    logic [CNT_W-1:0] r_cnt [3];

    rep_st_t          w_st_nx [3];
    logic [CNT_W-1:0] w_cnt_nx [3];
    logic [4:0]       w_rise;
    logic [2:0]       w_fire;
    logic [2:0]       w_kill;
    logic [4:0]       w_grant;
    logic [2:0]       w_code;
    logic [4:0]       w_set;
    logic [4:0]       w_clr;
    logic             w_load;
    logic             w_take;

    assign w_rise = i_btn_lvl & ~r_prev;
    // A fresh press on one horizontal direction cancels the opposite one;
    // simultaneous presses of both leave each to its own rise.
    assign w_kill = {1'b0, w_rise[0] & ~w_rise[1], w_rise[1] & ~w_rise[0]};

    always_comb begin
        w_st_nx  = r_st;
        w_cnt_nx = r_cnt;
        w_fire   = '0;
        for (int k = 0; k < 3; k++) begin
            if (!i_btn_lvl[k] || !i_enable || w_kill[k]) begin
                w_st_nx[k]  = IDLE;
                w_cnt_nx[k] = '0;
            end else if (w_rise[k]) begin
                w_st_nx[k]  = DELAY;
                w_cnt_nx[k] = '0;
            end else if (i_tick && r_st[k] == DELAY) begin
                w_fire[k]   = (r_cnt[k] == DAS_LAST);
                w_st_nx[k]  = w_fire[k] ? REPEAT : DELAY;
                w_cnt_nx[k] = w_fire[k] ? '0 : r_cnt[k] + 1'b1;
            end else if (i_tick && r_st[k] == REPEAT) begin
                w_fire[k]   = (r_cnt[k] == ARR_LAST);
                w_cnt_nx[k] = w_fire[k] ? '0 : r_cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        w_code  = 3'd0;
        if (r_req[4]) begin
            w_grant = 5'b10000;
            w_code  = 3'd5;
        end else if (r_req[3]) begin
            w_grant = 5'b01000;
            w_code  = 3'd4;
        end else if (r_req[0]) begin
            w_grant = 5'b00001;
            w_code  = 3'd1;
        end else if (r_req[1]) begin
            w_grant = 5'b00010;
            w_code  = 3'd2;
        end else if (r_req[2]) begin
            w_grant = 5'b00100;
            w_code  = 3'd3;
        end
    end

    assign w_load = ~r_valid | cmd.cmd_ready;
    assign w_take = w_load & i_enable & (|r_req);
    assign w_set  = {w_rise[4:3], w_rise[2:0] | w_fire} & {5{i_enable}};
    assign w_clr  = ({5{w_take}} & w_grant) | {2'b00, w_kill};

    always_ff @(posedge clk) begin
        r_prev <= i_btn_lvl;
        if (rst) begin
            r_req   <= '0;
            r_valid <= 1'b0;
            r_code  <= 3'd0;
            for (int k = 0; k < 3; k++) begin
                r_st[k]  <= IDLE;
                r_cnt[k] <= '0;
            end
        end else begin
            // Set takes precedence so a press landing on its own grant is not lost.
            r_req <= i_enable ? ((r_req & ~w_clr) | w_set) : '0;
            for (int k = 0; k < 3; k++) begin
                r_st[k]  <= w_st_nx[k];
                r_cnt[k] <= w_cnt_nx[k];
            end
            if (w_load) begin
                r_valid <= w_take;
                r_code  <= w_take ? w_code : 3'd0;
            end
        end
    end

    assign cmd.cmd_valid = r_valid;
    assign cmd.cmd_code  = r_code;
endmodule

// File: tb/tb_tetris_input_sched.sv
// tb_tetris_input_sched: directed stimulus with an expected-command queue drained by a monitor.
module tb_tetris_input_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b1;
    logic [4:0] btn = 5'b0;
    int         total = 0;
    int         bad = 0;
    int         exp_q[$];
    logic       hold_v = 1'b0;
    logic [2:0] hold_c = 3'd0;

    tetris_input_sched_if bus ();

    tetris_input_sched dut (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (tick),
        .i_enable  (enable),
        .i_btn_lvl (btn),
        .cmd       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", int'(bus.cmd_valid), 1);
                chk("stall_code", int'(bus.cmd_code), int'(hold_c));
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got code %0d expected none", bus.cmd_code);
                end else begin
                    chk("cmd_code", int'(bus.cmd_code), exp_q.pop_front());
                end
            end
            hold_v <= bus.cmd_valid && !bus.cmd_ready;
            hold_c <= bus.cmd_code;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        cyc(4);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        bus.cmd_ready = 1'b1;
        btn = 5'b11111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("reset_valid", int'(bus.cmd_valid), 0);
        end
        chk("reset_code", int'(bus.cmd_code), 0);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            ticks(1);
            chk("held_through_reset", int'(bus.cmd_valid), 0);
        end
        btn = 5'b0;
        drain("reset_drain");

        exp_q.push_back(4);
        btn[3] = 1'b1;
        cyc(1);
        chk("rotate_lat1_valid", int'(bus.cmd_valid), 0);
        cyc(1);
        chk("rotate_lat2_valid", int'(bus.cmd_valid), 1);
        chk("rotate_lat2_code", int'(bus.cmd_code), 4);
        cyc(1);
        chk("rotate_once", int'(bus.cmd_valid), 0);
        ticks(100);
        btn[3] = 1'b0;
        drain("rotate_drain");

        repeat (5) exp_q.push_back(1);
        btn[0] = 1'b1;
        ticks(30);
        btn[0] = 1'b0;
        drain("repeat_drain");

        bus.cmd_ready = 1'b0;
        btn = 5'b11001;
        cyc(10);
        chk("bp_valid", int'(bus.cmd_valid), 1);
        chk("bp_code", int'(bus.cmd_code), 5);
        exp_q.push_back(5);
        exp_q.push_back(4);
        exp_q.push_back(1);
        bus.cmd_ready = 1'b1;
        cyc(1);
        chk("arb_second", int'(bus.cmd_code), 4);
        cyc(1);
        chk("arb_third", int'(bus.cmd_code), 1);
        cyc(1);
        chk("arb_idle", int'(bus.cmd_valid), 0);
        btn = 5'b0;
        drain("arb_drain");

        exp_q.push_back(1);
        exp_q.push_back(2);
        btn[0] = 1'b1;
        ticks(5);
        btn[1] = 1'b1;
        ticks(3);
        btn[1] = 1'b0;
        ticks(40);
        btn[0] = 1'b0;
        drain("conflict_drain");

        repeat (3) exp_q.push_back(3);
        btn[2] = 1'b1;
        ticks(17);
        bus.cmd_ready = 1'b0;
        ticks(4);
        cyc(1);
        chk("en_pending_valid", int'(bus.cmd_valid), 1);
        chk("en_pending_code", int'(bus.cmd_code), 3);
        enable = 1'b0;
        ticks(20);
        bus.cmd_ready = 1'b1;
        cyc(3);
        chk("en_off_idle", int'(bus.cmd_valid), 0);
        enable = 1'b1;
        ticks(30);
        btn[2] = 1'b0;
        drain("enable_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tetris_input_sched.md
Name: tetris_input_sched

Overview:
- Converts the five debounced Tetris button levels into a single stream of game commands for the game-logic FSM.
- Per button: edge detection. Left, right and down also get auto-repeat (delayed auto-shift, then a fixed repeat rate).
- A fixed-priority arbiter serialises simultaneous requests onto one valid/ready command port.
- Sits between the per-button debouncers and the game engine; all timing is counted in game ticks.

Parameters:
DAS_TICKS, 16, ticks a shift button must stay held after its press before the first repeat; legal range 1..2^CNT_W-1
ARR_TICKS, 4, ticks between successive repeats once repeating; legal range 1..2^CNT_W-1
CNT_W, 8, width of each repeat counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle game-tick strobe
enable  in  1  game running; low = suppress new commands
btn_lvl  in  5  debounced levels: [0] left, [1] right, [2] down, [3] rotate, [4] hard drop
cmd_ready  in  1  game engine accepts cmd this cycle
cmd_valid  out  1  command available
cmd_code  out  3  0 none, 1 left, 2 right, 3 down, 4 rotate, 5 drop

Behaviour:
- Reset (rst sampled high at a clk edge):
  - cmd_valid=0, cmd_code=0, all req bits 0, all repeat FSMs IDLE, counters 0.
  - btn_prev is loaded with btn_lvl, so buttons held through reset never produce a press.
- Edge detect:
  - btn_prev <= btn_lvl every cycle, including while enable=0.
  - rise = btn_lvl & ~btn_prev.
- Request register req[4:0]:
  - A bit sets on that button's rise, or on a repeat fire (bits 0..2 only).
  - A bit clears when the arbiter grants it.
  - Set and clear in the same cycle: set wins.
  - A repeated set while already pending merges; there is no count.
- Repeat FSM, one each for left, right, down; states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on rise; cnt=0.
  - DELAY: each tick cnt++. A tick with cnt==DAS_TICKS-1 fires a req and moves to REPEAT with cnt=0.
  - REPEAT: each tick cnt++. A tick with cnt==ARR_TICKS-1 fires a req and sets cnt=0. ARR_TICKS=1 fires on every tick.
  - Any state -> IDLE when the level is low.
  - Rise and tick in the same cycle: rise wins, cnt=0, that tick is not counted.
  - Left/right conflict: a rise on one forces the other's FSM to IDLE and clears its req bit. The suppressed direction stays IDLE until its own next rise.
  - Rotate and drop never repeat.
- Arbiter / output register:
  - Load condition: cmd_valid==0, or cmd_valid & cmd_ready.
  - When the load condition holds, enable=1 and req!=0: load the highest-priority pending request, set cmd_valid=1, clear that req bit.
  - Priority: drop > rotate > left > right > down.
  - When the load condition holds and nothing is loaded: cmd_valid=0, cmd_code=0.
  - While cmd_valid=1 & cmd_ready=0, cmd_code holds stable.
  - With ready held high, back-to-back commands issue one per cycle.
- Latency: btn_lvl rises before edge N -> req set at N -> cmd_valid=1 after edge N+1, i.e. 2 cycles when the port is free.
- enable=0:
  - req cleared and FSMs held IDLE every cycle; no new loads.
  - A command already valid stays valid until accepted; the handshake is never retracted.
  - On enable rising, held buttons do not fire; a new rise is required.
- Reset mid-operation: an in-flight command is dropped immediately and all state returns to reset values.

Test Plan:
- Reset:
  - Stimulus: btn_lvl=5'b11111 through a 3-cycle rst; hold btn_lvl for 50 cycles after release, with ticks.
  - Required: cmd_valid stays 0 throughout.
- Single rotate, cmd_ready=1:
  - Stimulus: btn_lvl[3] rises before edge 10, then held for 100 ticks.
  - Required: cmd_valid=1 with code 4 for exactly one cycle after edge 11; no further commands.
- Auto-repeat (DAS=16, ARR=4):
  - Stimulus: left held for 30 ticks.
  - Required: exactly 5 left commands — one at press, then at the ticks ending DELAY (16th) and REPEAT (20th, 24th, 28th).
- Arbitration with backpressure:
  - Stimulus: cmd_ready=0; left, rotate and drop rise in the same cycle; hold 10 cycles, then cmd_ready=1.
  - Required: code 5 held stable while ready is low; then codes 5, 4, 1 on consecutive cycles; then cmd_valid=0.
- Left/right conflict:
  - Stimulus: hold left; press right during left's DELAY; release right while still holding left for 40 ticks.
  - Required: exactly one left and one right command; no left repeats afterwards.
- enable drop mid-repeat:
  - Stimulus: down in REPEAT with a command valid and cmd_ready=0; enable->0 for 20 ticks, then cmd_ready=1.
  - Required: the pending command completes once; no new down commands while enable=0 or after enable returns with down still held.
